// File: rtl/batch_norm.sv
// Per-channel affine batch-norm stage: y[i] = A[i]*x[i] + B[i] mod 2^Data_Width.
// One registered stage; out_row holds its last result when no new row arrives.
module batch_norm #(
  parameter int Data_Width = 32,
  parameter int N          = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N*Data_Width-1:0] in_row,
  input  logic                    INBatch_Valid,
  input  logic [Data_Width-1:0]   A [0:N-1],
  input  logic [Data_Width-1:0]   B [0:N-1],
  output logic [N*Data_Width-1:0] out_row,
  output logic                    OutBatch_Valid
);

  logic [N*Data_Width-1:0] lane_res;

  // Full product then truncation: low bits match signed and unsigned alike
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [2*Data_Width-1:0] prod;
    logic [2*Data_Width-1:0] sum;
    assign prod = A[i] * in_row[i*Data_Width +: Data_Width];
    assign sum  = prod + {{Data_Width{1'b0}}, B[i]};
    assign lane_res[i*Data_Width +: Data_Width] = sum[Data_Width-1:0];
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      out_row        <= '0;
      OutBatch_Valid <= 1'b0;
    end else begin
      OutBatch_Valid <= INBatch_Valid;
      if (INBatch_Valid) out_row <= lane_res;
    end
  end

endmodule

// File: tb/tb_batch_norm.sv
// Self-checking bench for batch_norm with N=4, Data_Width=32.
// Directed scenarios plus randomized rows against an arithmetic model.
module tb_batch_norm;
  localparam int DW = 32;
  localparam int N  = 4;

  typedef logic [DW-1:0] vec_t [0:N-1];

  logic            CLK;
  logic            RST;
  logic [N*DW-1:0] in_row;
  logic            INBatch_Valid;
  logic [DW-1:0]   A [0:N-1];
  logic [DW-1:0]   B [0:N-1];
  logic [N*DW-1:0] out_row;
  logic            OutBatch_Valid;

  int n_cmp = 0;
  int n_bad = 0;

  batch_norm #(.Data_Width(DW), .N(N)) dut (
    .CLK(CLK),
    .RST(RST),
    .in_row(in_row),
    .INBatch_Valid(INBatch_Valid),
    .A(A),
    .B(B),
    .out_row(out_row),
    .OutBatch_Valid(OutBatch_Valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [N*DW-1:0] pack(input vec_t v);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v[i];
    return r;
  endfunction

  // Reference: exact 64-bit arithmetic, then reduce modulo 2^32
  function automatic logic [N*DW-1:0] model(input vec_t a, input vec_t b,
                                            input vec_t x);
    logic [N*DW-1:0] r;
    longint unsigned full;
    for (int i = 0; i < N; i++) begin
      full = longint'(a[i]) * longint'(x[i]) + longint'(b[i]);
      r[i*DW +: DW] = DW'(full % (64'd1 << DW));
    end
    return r;
  endfunction

  task automatic drive(input vec_t a, input vec_t b, input vec_t x,
                       input logic v);
    for (int i = 0; i < N; i++) begin
      A[i] = a[i];
      B[i] = b[i];
    end
    in_row = pack(x);
    INBatch_Valid = v;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    vec_t a, b, x;
    for (int i = 0; i < N; i++) begin
      a[i] = $urandom; b[i] = $urandom; x[i] = $urandom;
    end
    RST = 1'b0;
    drive(a, b, x, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (out_row !== '0) begin
        n_bad++;
        $display("FAIL reset_out got %h exp 0", out_row);
      end
      n_cmp++;
      if (OutBatch_Valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_valid got %b exp 0", OutBatch_Valid);
      end
    end
    RST = 1'b1;
    INBatch_Valid = 1'b0;
    step();
    n_cmp++;
    if (OutBatch_Valid !== 1'b0 || out_row !== '0) begin
      n_bad++;
      $display("FAIL post_reset got v=%b out=%h exp v=0 out=0",
               OutBatch_Valid, out_row);
    end
  endtask

  task automatic test_basic();
    vec_t a = '{1, 1, 1, 1};
    vec_t b = '{0, 2, 4, 6};
    vec_t x = '{1, 2, 3, 4};
    vec_t e = '{1, 4, 7, 10};
    drive(a, b, x, 1'b1);
    step();
    n_cmp++;
    if (out_row !== pack(e) || OutBatch_Valid !== 1'b1) begin
      n_bad++;
      $display("FAIL basic got v=%b out=%h exp v=1 out=%h",
               OutBatch_Valid, out_row, pack(e));
    end
    INBatch_Valid = 1'b0;
    x = '{9, 9, 9, 9};
    in_row = pack(x);
    step();
    n_cmp++;
    if (out_row !== pack(e) || OutBatch_Valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_hold got v=%b out=%h exp v=0 out=%h",
               OutBatch_Valid, out_row, pack(e));
    end
  endtask

  task automatic test_wrap();
    vec_t a = '{3, 0, 32'hFFFF_FFFF, 32'h0001_0000};
    vec_t b = '{5, 7, 1, 0};
    vec_t x = '{4, 9, 1, 32'h0001_0000};
    vec_t e = '{17, 7, 0, 0};
    drive(a, b, x, 1'b1);
    step();
    INBatch_Valid = 1'b0;
    n_cmp++;
    if (out_row !== pack(e) || OutBatch_Valid !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap got v=%b out=%h exp v=1 out=%h",
               OutBatch_Valid, out_row, pack(e));
    end
    step();
  endtask

  task automatic test_back_to_back();
    vec_t a = '{2, 2, 2, 2};
    vec_t b = '{1, 1, 1, 1};
    vec_t xs [3];
    vec_t es [3];
    xs[0] = '{1, 2, 3, 4};
    xs[1] = '{5, 6, 7, 8};
    xs[2] = '{0, 0, 0, 0};
    es[0] = '{3, 5, 7, 9};
    es[1] = '{11, 13, 15, 17};
    es[2] = '{1, 1, 1, 1};
    for (int k = 0; k < 3; k++) begin
      drive(a, b, xs[k], 1'b1);
      step();
      n_cmp++;
      if (out_row !== pack(es[k]) || OutBatch_Valid !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_%0d got v=%b out=%h exp v=1 out=%h",
                 k, OutBatch_Valid, out_row, pack(es[k]));
      end
    end
    INBatch_Valid = 1'b0;
    step();
    n_cmp++;
    if (OutBatch_Valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end got v=%b exp v=0", OutBatch_Valid);
    end
  endtask

  task automatic test_reset_mid();
    vec_t a = '{7, 8, 9, 10};
    vec_t b = '{1, 2, 3, 4};
    vec_t x = '{5, 6, 7, 8};
    vec_t e = '{36, 50, 66, 84};
    drive(a, b, x, 1'b1);
    step();
    n_cmp++;
    if (out_row !== pack(e) || OutBatch_Valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_first got v=%b out=%h exp v=1 out=%h",
               OutBatch_Valid, out_row, pack(e));
    end
    x = '{11, 12, 13, 14};
    in_row = pack(x);
    RST = 1'b0;
    step();
    n_cmp++;
    if (out_row !== '0 || OutBatch_Valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_reset got v=%b out=%h exp v=0 out=0",
               OutBatch_Valid, out_row);
    end
    RST = 1'b1;
    INBatch_Valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (out_row !== '0 || OutBatch_Valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rmid_after got v=%b out=%h exp v=0 out=0",
                 OutBatch_Valid, out_row);
      end
    end
  endtask

  task automatic test_random();
    vec_t a, b, x;
    logic v;
    logic [N*DW-1:0] exp_out = '0;
    logic exp_v;
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < N; i++) begin
        a[i] = $urandom; b[i] = $urandom; x[i] = $urandom;
        if ($urandom_range(0, 7) == 0) a[i] = 32'hFFFF_FFFF;
      end
      v = ($urandom_range(0, 9) < 6);
      drive(a, b, x, v);
      if (v) exp_out = model(a, b, x);
      exp_v = v;
      step();
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (out_row[i*DW +: DW] !== exp_out[i*DW +: DW]) begin
          n_bad++;
          $display("FAIL rand_lane%0d row %0d got %h exp %h", i, k,
                   out_row[i*DW +: DW], exp_out[i*DW +: DW]);
        end
      end
      n_cmp++;
      if (OutBatch_Valid !== exp_v) begin
        n_bad++;
        $display("FAIL rand_valid row %0d got %b exp %b", k,
                 OutBatch_Valid, exp_v);
      end
    end
    INBatch_Valid = 1'b0;
  endtask

  initial begin
    RST = 1'b0;
    INBatch_Valid = 1'b0;
    in_row = '0;
    for (int i = 0; i < N; i++) begin
      A[i] = '0;
      B[i] = '0;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/batch_norm.md
# batch_norm

Per-channel affine batch-normalisation stage for the MobileViT accelerator datapath. It takes one row of N channel values and applies a precomputed scale A[i] and bias B[i] to each lane: y[i] = A[i]·x[i] + B[i]. It produces the registered result one clock later, together with a valid pulse. It sits after the convolution/matmul output and before the activation stage; A and B are folded from the mean, variance, gamma and beta by software or an upstream block.

## Interface

Parameters:
- Data_Width, 32, bit width of each lane value, coefficient and result.
- N, 32, number of lanes (channels) per row. The bench also uses N=4.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RST  input  1  reset; synchronous and active-low.
- in_row  input  N*Data_Width  packed input row; lane i is in_row[i*Data_Width +: Data_Width].
- INBatch_Valid  input  1  in_row, A and B are valid this cycle.
- A  input  unpacked array [0:N-1] of Data_Width  per-lane scale.
- B  input  unpacked array [0:N-1] of Data_Width  per-lane bias.
- out_row  output  N*Data_Width  packed result row; lane i is out_row[i*Data_Width +: Data_Width].
- OutBatch_Valid  output  1  out_row holds a new result this cycle.

## Operation

- Each lane i computes A[i]*x[i] + B[i], with x[i] taken from the lane i slice of in_row.
- Arithmetic is modulo 2^Data_Width:
  - The full product is formed.
  - B is added.
  - The low Data_Width bits are kept.
  - This is bit-identical for unsigned and two's-complement operands.
  - There is no saturation and no overflow flag.
- All N lanes operate in parallel and independently; there are no shared resources.
- When INBatch_Valid=1 at a rising edge (and RST=1):
  - in_row, A and B are sampled.
  - All lanes are computed.
  - Results are registered into out_row.
  - OutBatch_Valid is set to 1.
- When INBatch_Valid=0 at a rising edge:
  - OutBatch_Valid is cleared to 0.
  - out_row holds its previous value.
- There is no backpressure; the block accepts a new row every cycle.
- There is no FSM; the datapath is a single registered stage.

## Timing

- Reset: when RST=0 at a rising edge, out_row becomes all zeros and OutBatch_Valid becomes 0. Reset takes priority over INBatch_Valid.
- Latency: 1 cycle. Valid input sampled at edge k appears on out_row, with OutBatch_Valid=1, from edge k until edge k+1.
- Throughput: 1 row per cycle. For back-to-back valid inputs, OutBatch_Valid stays high and out_row updates every cycle.
- Single-cycle input pulse: OutBatch_Valid is high for exactly one cycle.
- Reset asserted mid-stream: in-flight results are discarded at that edge, and outputs go to zero and 0 as above.
- A and B only need to be stable at edges where INBatch_Valid=1.
- Output changes only on clock edges; there are no combinational input-to-output paths.

## Test plan

- Reset: hold RST=0 for 2 edges with INBatch_Valid=1 -> out_row=0, OutBatch_Valid=0; after release with valid low, OutBatch_Valid stays 0.
- Basic row, N=4:
  - Stimulus: A=[1,1,1,1], B=[0,2,4,6], x=[1,2,3,4], one-cycle valid pulse.
  - Response: out_row lanes=[1,4,7,10] and OutBatch_Valid=1 for exactly the cycle after the sampling edge, then valid drops and out_row holds [1,4,7,10].
- Scaling and wrap:
  - Stimulus: A=[3,0,0xFFFFFFFF,0x10000], B=[5,7,1,0], x=[4,9,1,0x10000].
  - Response: [17,7,0,0] (truncated modulo 2^32).
- Back-to-back: three consecutive valid rows with x=[1..4], then x=[5..8], then x=[0,0,0,0], using A=2, B=1 for all lanes -> outputs [3,5,7,9], [11,13,15,17], [1,1,1,1] on successive cycles, with OutBatch_Valid high for 3 cycles.
- Reset mid-stream: assert RST=0 on the edge where the second of two valid rows is sampled -> outputs zero and valid 0 on that edge; no stale result appears afterward.
- Random: 1000 random rows with random A, B and random valid gaps, checked lane-by-lane against the modulo-2^32 reference model with 1-cycle latency.
